// File: rtl/cpu_pkg.sv
// Shared core definitions: data width, boot PC, opcodes, fetch FSM states and
// the fetch-stage next-PC action encoding.
package cpu_pkg;

   localparam int unsigned XLEN = 32;
   localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

   localparam logic [5:0] OP_BEQ = 6'b000100;
   localparam logic [5:0] OP_J   = 6'b000010;

   typedef enum logic {ST_BOOT, ST_RUN} fetch_state_e;

   // What the fetch stage does on the coming edge.
   typedef enum logic [1:0] {ACT_HOLD, ACT_REDIR, ACT_FLUSH, ACT_FETCH} fetch_act_e;

   function automatic logic [XLEN-1:0] branch_target(input logic [XLEN-1:0] pc4,
                                                     input logic [15:0] imm);
      return pc4 + {{14{imm[15]}}, imm, 2'b00};
   endfunction

   function automatic logic [XLEN-1:0] jump_target(input logic [XLEN-1:0] pc4,
                                                   input logic [25:0] jidx);
      return {pc4[31:28], jidx, 2'b00};
   endfunction

endpackage

// File: rtl/fetch_pc_sel.sv
// Combinational next-PC select: jump > branch > flush > stall > sequential fetch.
module fetch_pc_sel
   import cpu_pkg::*;
(
   input  logic             run,
   input  logic [XLEN-1:0]  pc,
   input  logic             jump,
   input  logic             branch_taken,
   input  logic             flush,
   input  logic             stall,
   input  logic [XLEN-1:0]  redir_pc4,
   input  logic [15:0]      redir_imm,
   input  logic [25:0]      redir_jidx,
   output logic [XLEN-1:0]  next_pc,
   output fetch_act_e       act
);

   always_comb begin
      next_pc = pc;
      act     = ACT_HOLD;
      if (run) begin
         if (jump) begin
            next_pc = jump_target(redir_pc4, redir_jidx);
            act     = ACT_REDIR;
         end else if (branch_taken) begin
            next_pc = branch_target(redir_pc4, redir_imm);
            act     = ACT_REDIR;
         end else if (flush) begin
            next_pc = pc + 32'd4;
            act     = ACT_FLUSH;
         end else if (!stall) begin
            next_pc = pc + 32'd4;
            act     = ACT_FETCH;
         end
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, boot FSM and IF/ID pipeline register.
// Define FETCH_PERF_CNT_EN to add the perf_fetch/perf_stall/perf_squash counters.
module fetch_stage
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
   parameter int unsigned IMEM_WORDS = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        flush,
   input  logic        branch_taken,
   input  logic        jump,
   input  logic [31:0] redir_pc4,
   input  logic [15:0] redir_imm,
   input  logic [25:0] redir_jidx,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_instr,
   output logic [31:0] ifid_instr,
   output logic [31:0] ifid_pc4,
   output logic        ifid_valid,
`ifdef FETCH_PERF_CNT_EN
   output logic [31:0] perf_fetch,
   output logic [31:0] perf_stall,
   output logic [31:0] perf_squash,
`endif
   output logic        pc_oob
);

   fetch_state_e state_q, state_d;
   fetch_act_e   act;
   logic [31:0]  pc_q, pc_d, pc_plus4;
   logic [31:0]  instr_d, pc4_d;
   logic         valid_d;

   assign pc_plus4  = pc_q + 32'd4;
   assign imem_addr = pc_q;
   assign pc_oob    = ({2'b00, pc_q[31:2]} >= IMEM_WORDS);

   fetch_pc_sel u_pc_sel (
      .run          (state_q == ST_RUN),
      .pc           (pc_q),
      .jump         (jump),
      .branch_taken (branch_taken),
      .flush        (flush),
      .stall        (stall),
      .redir_pc4    (redir_pc4),
      .redir_imm    (redir_imm),
      .redir_jidx   (redir_jidx),
      .next_pc      (pc_d),
      .act          (act)
   );

   always_comb begin
      state_d = state_q;
      instr_d = ifid_instr;
      pc4_d   = ifid_pc4;
      valid_d = ifid_valid;
      unique case (state_q)
         ST_BOOT: state_d = ST_RUN;
         ST_RUN:  state_d = ST_RUN;
         default: state_d = ST_BOOT;
      endcase
      unique case (act)
         ACT_REDIR: valid_d = 1'b0;
         // Flush still captures the word so IF/ID data tracks the fetched PC.
         ACT_FLUSH: begin
            instr_d = imem_instr;
            pc4_d   = pc_plus4;
            valid_d = 1'b0;
         end
         ACT_FETCH: begin
            instr_d = imem_instr;
            pc4_d   = pc_plus4;
            valid_d = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_BOOT;
         pc_q       <= RESET_PC;
         ifid_instr <= 32'd0;
         ifid_pc4   <= 32'd0;
         ifid_valid <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         ifid_instr <= instr_d;
         ifid_pc4   <= pc4_d;
         ifid_valid <= valid_d;
      end
   end

`ifdef FETCH_PERF_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_fetch  <= 32'd0;
         perf_stall  <= 32'd0;
         perf_squash <= 32'd0;
      end else if (state_q == ST_RUN) begin
         if (act == ACT_FETCH) perf_fetch <= perf_fetch + 32'd1;
         if (act == ACT_HOLD) perf_stall <= perf_stall + 32'd1;
         if (act == ACT_REDIR || act == ACT_FLUSH) perf_squash <= perf_squash + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: stimulus queues expected IF/ID words,
// a negedge monitor pops and compares whenever ifid_valid is high.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall, flush, branch_taken, jump;
   logic [31:0] redir_pc4;
   logic [15:0] redir_imm;
   logic [25:0] redir_jidx;
   logic [31:0] imem_addr, imem_instr, ifid_instr, ifid_pc4;
   logic        ifid_valid, pc_oob;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_fetch, perf_stall, perf_squash;
`endif

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc4;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   function automatic logic [31:0] mem(input logic [31:0] a);
      return 32'hC000_0000 + a;
   endfunction

   assign imem_instr = mem(imem_addr);

   fetch_stage #(.RESET_PC(32'h0000_0000), .IMEM_WORDS(64)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .stall        (stall),
      .flush        (flush),
      .branch_taken (branch_taken),
      .jump         (jump),
      .redir_pc4    (redir_pc4),
      .redir_imm    (redir_imm),
      .redir_jidx   (redir_jidx),
      .imem_addr    (imem_addr),
      .imem_instr   (imem_instr),
      .ifid_instr   (ifid_instr),
      .ifid_pc4     (ifid_pc4),
      .ifid_valid   (ifid_valid),
`ifdef FETCH_PERF_CNT_EN
      .perf_fetch   (perf_fetch),
      .perf_stall   (perf_stall),
      .perf_squash  (perf_squash),
`endif
      .pc_oob       (pc_oob)
   );

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, want);
      end
   endtask

   // One clock: optionally queue the word fetched from exp_pc, then check valid/address.
   task automatic tick(input string name, input logic exp_v, input logic [31:0] exp_pc,
                       input logic [31:0] exp_addr);
      exp_t e;
      @(posedge clk);
      if (exp_v) begin
         e.instr = mem(exp_pc);
         e.pc4   = exp_pc + 32'd4;
         sb_q.push_back(e);
      end
      #2;
      chk({name, "_valid"}, {31'd0, ifid_valid}, {31'd0, exp_v});
      chk({name, "_addr"}, imem_addr, exp_addr);
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (rst_n === 1'b1 && ifid_valid === 1'b1) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_valid: got instr %h pc4 %h expected no entry",
                     ifid_instr, ifid_pc4);
         end else begin
            e = sb_q.pop_front();
            chk("ifid_instr", ifid_instr, e.instr);
            chk("ifid_pc4", ifid_pc4, e.pc4);
         end
      end
   end

   initial begin
      #50000;
      $display("FAIL timeout: got no finish expected finish before 50000");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; stall = 1'b0; flush = 1'b0; branch_taken = 1'b0; jump = 1'b0;
      redir_pc4 = 32'd0; redir_imm = 16'd0; redir_jidx = 26'd0;
      #3;
      chk("rst_addr", imem_addr, 32'd0);
      chk("rst_valid", {31'd0, ifid_valid}, 32'd0);
      chk("rst_instr", ifid_instr, 32'd0);
      chk("rst_pc4", ifid_pc4, 32'd0);
`ifdef FETCH_PERF_CNT_EN
      chk("rst_perf_fetch", perf_fetch, 32'd0);
`endif
      #9 rst_n = 1'b1;

      // Boot cycle then sequential fetch
      tick("boot", 1'b0, 32'd0, 32'd0);
      tick("f0", 1'b1, 32'd0, 32'd4);
      tick("f4", 1'b1, 32'd4, 32'd8);

      // Stall three cycles at PC=8
      stall = 1'b1;
      repeat (3) tick("stall", 1'b1, 32'd4, 32'd8);
      stall = 1'b0;
      tick("resume", 1'b1, 32'd8, 32'd12);
`ifdef FETCH_PERF_CNT_EN
      chk("perf_stall", perf_stall, 32'd3);
`endif

      // Taken branch with negative offset: 36 - 28 = 8
      branch_taken = 1'b1; redir_pc4 = 32'd36; redir_imm = 16'hFFF9;
      tick("beq", 1'b0, 32'd0, 32'd8);
      branch_taken = 1'b0;
      tick("after_beq", 1'b1, 32'd8, 32'd12);

      // Jump beats branch and stall
      jump = 1'b1; branch_taken = 1'b1; stall = 1'b1;
      redir_pc4 = 32'd72; redir_jidx = 26'd14; redir_imm = 16'h0004;
      tick("jmp_all", 1'b0, 32'd0, 32'd56);
      jump = 1'b0; branch_taken = 1'b0; stall = 1'b0;
      tick("after_jmp", 1'b1, 32'd56, 32'd60);

      // Flush: PC advances, valid drops, data still captured
      flush = 1'b1;
      tick("flush", 1'b0, 32'd0, 32'd64);
      chk("flush_pc4", ifid_pc4, 32'd64);
      flush = 1'b0;
      tick("after_flush", 1'b1, 32'd64, 32'd68);
      chk("oob_68", {31'd0, pc_oob}, 32'd0);

      // Jump to top of address space, then wrap to 0
      jump = 1'b1; redir_pc4 = 32'hF000_0000; redir_jidx = 26'h3FF_FFFF;
      tick("jmp_top", 1'b0, 32'd0, 32'hFFFF_FFFC);
      chk("oob_top", {31'd0, pc_oob}, 32'd1);
      jump = 1'b0;
      tick("wrap", 1'b1, 32'hFFFF_FFFC, 32'd0);
      chk("oob_0", {31'd0, pc_oob}, 32'd0);

      // pc_oob boundary at word index 64
      jump = 1'b1; redir_pc4 = 32'd0; redir_jidx = 26'd64;
      tick("jmp_256", 1'b0, 32'd0, 32'd256);
      chk("oob_256", {31'd0, pc_oob}, 32'd1);
      redir_jidx = 26'd63;
      tick("jmp_252", 1'b0, 32'd0, 32'd252);
      chk("oob_252", {31'd0, pc_oob}, 32'd0);
      jump = 1'b0;

      // Negative branch offset wraps below zero: 4 - 8
      branch_taken = 1'b1; redir_pc4 = 32'd4; redir_imm = 16'hFFFE;
      tick("beq_wrap", 1'b0, 32'd0, 32'hFFFF_FFFC);
      branch_taken = 1'b0;
      tick("fetch_top", 1'b1, 32'hFFFF_FFFC, 32'd0);

      // Async reset during stall with a pending redirect
      @(negedge clk);
      stall = 1'b1; branch_taken = 1'b1; redir_pc4 = 32'd100; redir_imm = 16'h0004;
      #1 rst_n = 1'b0;
      #1;
      chk("async_addr", imem_addr, 32'd0);
      chk("async_valid", {31'd0, ifid_valid}, 32'd0);
      chk("async_instr", ifid_instr, 32'd0);
      chk("async_pc4", ifid_pc4, 32'd0);
`ifdef FETCH_PERF_CNT_EN
      chk("async_perf_fetch", perf_fetch, 32'd0);
      chk("async_perf_stall", perf_stall, 32'd0);
      chk("async_perf_squash", perf_squash, 32'd0);
`endif
      @(posedge clk);
      #2;
      chk("held_rst_addr", imem_addr, 32'd0);
      stall = 1'b0; branch_taken = 1'b0;
      rst_n = 1'b1;
      tick("reboot", 1'b0, 32'd0, 32'd0);
      tick("refetch", 1'b1, 32'd0, 32'd4);

      @(negedge clk);
      #1;
      chk("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
